// File: rtl/alu_cmd_pkg.sv
// rtl/alu_cmd_pkg.sv - shared states, opcodes and error codes for the ALU command controller
package alu_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    GET_FUN,
    ALU_REQ,
    ALU_WAIT,
    SEND_LO,
    SEND_HI
  } state_t;

  localparam logic [7:0] CMD_OPER   = 8'hCC;
  localparam logic [7:0] CMD_NOOPER = 8'hDD;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_CMD = 2'd1;
  localparam logic [1:0] ERR_BAD_FUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - decodes RX command frames, drives the ALU, and returns the
// 16-bit result to the TX FIFO as low byte then high byte
module alu_cmd_ctrl import alu_cmd_pkg::*; #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    WAIT_MAX   = 4,
  parameter logic [DATA_WIDTH-1:0] CMD_OPER   = DATA_WIDTH'(alu_cmd_pkg::CMD_OPER),
  parameter logic [DATA_WIDTH-1:0] CMD_NOOPER = DATA_WIDTH'(alu_cmd_pkg::CMD_NOOPER)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_VALID,
  input  logic                    FIFO_FULL,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  output logic [3:0]              ALU_FUN,
  output logic                    ALU_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    BUSY,
  output logic                    CMD_ERR,
  output logic [1:0]              ERR_CODE
);

  localparam int            CW        = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);
  localparam logic [CW-1:0] WAIT_SAT  = CW'(WAIT_MAX);

  state_t                  state, state_nxt;
  logic [2*DATA_WIDTH-1:0] result;
  logic [CW-1:0]           wait_cnt;
  logic                    err_set;
  logic [1:0]              err_code_nxt;
  logic                    ld_a, ld_b, ld_fun, ld_res;
  logic                    fun_ok;
  logic                    tx_fire;

  // Function codes live in the low nibble; 4'hF is reserved.
  assign fun_ok  = (RX_P_DATA[DATA_WIDTH-1:4] == '0) && (RX_P_DATA[3:0] != 4'hF);
  assign tx_fire = ((state == SEND_LO) || (state == SEND_HI)) && !FIFO_FULL;

  assign ALU_EN   = (state == ALU_REQ);
  assign BUSY     = (state != IDLE);
  assign TX_D_VLD = tx_fire;

  always_comb begin
    TX_P_DATA = '0;
    case (state)
      SEND_LO: TX_P_DATA = result[DATA_WIDTH-1:0];
      SEND_HI: TX_P_DATA = result[2*DATA_WIDTH-1:DATA_WIDTH];
      default: TX_P_DATA = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    err_set      = 1'b0;
    err_code_nxt = ERR_NONE;
    ld_a         = 1'b0;
    ld_b         = 1'b0;
    ld_fun       = 1'b0;
    ld_res       = 1'b0;
    case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_OPER)        state_nxt = GET_A;
          else if (RX_P_DATA == CMD_NOOPER) state_nxt = GET_FUN;
          else begin
            err_set      = 1'b1;
            err_code_nxt = ERR_BAD_CMD;
          end
        end
      end
      GET_A: begin
        if (RX_D_VLD) begin
          ld_a      = 1'b1;
          state_nxt = GET_B;
        end
      end
      GET_B: begin
        if (RX_D_VLD) begin
          ld_b      = 1'b1;
          state_nxt = GET_FUN;
        end
      end
      GET_FUN: begin
        if (RX_D_VLD) begin
          if (fun_ok) begin
            ld_fun    = 1'b1;
            state_nxt = ALU_REQ;
          end else begin
            err_set      = 1'b1;
            err_code_nxt = ERR_BAD_FUN;
            state_nxt    = IDLE;
          end
        end
      end
      ALU_REQ: state_nxt = ALU_WAIT;
      ALU_WAIT: begin
        if (OUT_VALID) begin
          ld_res    = 1'b1;
          state_nxt = SEND_LO;
        end else if (wait_cnt == WAIT_LAST) begin
          err_set      = 1'b1;
          err_code_nxt = ERR_TIMEOUT;
          state_nxt    = IDLE;
        end
      end
      SEND_LO: if (tx_fire) state_nxt = SEND_HI;
      SEND_HI: if (tx_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands persist across frames so a no-operand frame can reuse them.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_FUN  <= '0;
      result   <= '0;
      wait_cnt <= '0;
      CMD_ERR  <= 1'b0;
      ERR_CODE <= ERR_NONE;
    end else begin
      if (ld_a)   ALU_A   <= RX_P_DATA;
      if (ld_b)   ALU_B   <= RX_P_DATA;
      if (ld_fun) ALU_FUN <= RX_P_DATA[3:0];
      if (ld_res) result  <= ALU_OUT;
      if (state == ALU_REQ)
        wait_cnt <= '0;
      else if ((state == ALU_WAIT) && !OUT_VALID && (wait_cnt != WAIT_SAT))
        wait_cnt <= wait_cnt + 1'b1;
      CMD_ERR <= err_set;
      if (err_set) ERR_CODE <= err_code_nxt;
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - scoreboard bench for alu_cmd_ctrl with a behavioural ALU and frame model
module tb_alu_cmd_ctrl;
  import alu_cmd_pkg::*;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] RX_P_DATA = '0;
  logic          RX_D_VLD = 1'b0;
  logic [15:0]   ALU_OUT = '0;
  logic          OUT_VALID = 1'b0;
  logic          FIFO_FULL = 1'b0;
  logic [DW-1:0] ALU_A, ALU_B, TX_P_DATA;
  logic [3:0]    ALU_FUN;
  logic          ALU_EN, TX_D_VLD, BUSY, CMD_ERR;
  logic [1:0]    ERR_CODE;

  alu_cmd_ctrl #(.DATA_WIDTH(DW), .WAIT_MAX(4)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .FIFO_FULL(FIFO_FULL),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .BUSY(BUSY),
    .CMD_ERR(CMD_ERR), .ERR_CODE(ERR_CODE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {int data; int cyc;} exp_t;
  typedef struct {int a; int b; int fun; int cyc;} op_t;
  exp_t tx_q[$];
  exp_t err_q[$];
  op_t  op_q[$];

  // Stand-in ALU behaviour; any fixed 16-bit function of the operands will do.
  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      default: return {a, b} ^ {f, 12'h5A3};
    endcase
  endfunction

  logic [7:0] m_a = '0, m_b = '0;
  logic [3:0] m_fun = '0;
  logic       alu_mute = 1'b0;
  logic       strict = 1'b1;
  logic       ff_rand = 1'b0;
  int         last_cyc;

  always begin : alu_resp
    logic [15:0] r;
    int d;
    @(negedge CLK);
    if (RST && ALU_EN && !alu_mute) begin
      r = alu_f(ALU_A, ALU_B, ALU_FUN);
      d = strict ? 0 : $urandom_range(0, 2);
      repeat (d + 1) @(posedge CLK);
      #1;
      OUT_VALID = 1'b1;
      ALU_OUT   = r;
      @(posedge CLK);
      #1;
      OUT_VALID = 1'b0;
      ALU_OUT   = 16'($urandom);
    end
  end

  always @(posedge CLK) begin
    #1;
    if (ff_rand) FIFO_FULL = ($urandom_range(0, 2) == 0);
  end

  always @(negedge CLK) begin : monitor
    op_t  o;
    exp_t e;
    if (RST) begin
      if (ALU_EN) begin
        chk("alu_en_expected", int'(op_q.size() > 0), 1);
        if (op_q.size() > 0) begin
          o = op_q.pop_front();
          chk("alu_a", ALU_A, o.a);
          chk("alu_b", ALU_B, o.b);
          chk("alu_fun", ALU_FUN, o.fun);
          if (o.cyc >= 0) chk("alu_en_cycle", cyc, o.cyc);
        end
      end
      if (CMD_ERR) begin
        chk("cmd_err_expected", int'(err_q.size() > 0), 1);
        if (err_q.size() > 0) begin
          e = err_q.pop_front();
          chk("err_code", ERR_CODE, e.data);
          if (e.cyc >= 0) chk("cmd_err_cycle", cyc, e.cyc);
        end
      end
      if (TX_D_VLD) begin
        chk("tx_while_full", FIFO_FULL, 0);
        chk("tx_expected", int'(tx_q.size() > 0), 1);
        if (tx_q.size() > 0) begin
          e = tx_q.pop_front();
          chk("tx_byte", TX_P_DATA, e.data);
          if (e.cyc >= 0) chk("tx_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge CLK);
    #1;
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    last_cyc  = cyc;
    @(posedge CLK);
    #1;
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'($urandom);
  endtask

  task automatic inject_junk();
    @(posedge CLK);
    #1;
    RX_P_DATA = CMD_OPER;
    RX_D_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (BUSY && k < 80);
    chk("idle_reached", BUSY, 0);
  endtask

  task automatic push_op(input int c);
    op_q.push_back('{int'(m_a), int'(m_b), int'(m_fun), c});
  endtask

  task automatic push_tx(input int lo_c, input int hi_c, input logic send_hi);
    logic [15:0] r;
    r = alu_f(m_a, m_b, m_fun);
    tx_q.push_back('{int'(r[7:0]), lo_c});
    if (send_hi) tx_q.push_back('{int'(r[15:8]), hi_c});
  endtask

  task automatic oper_frame(input logic [7:0] a, input logic [7:0] b);
    send(CMD_OPER);
    send(a);
    m_a = a;
    send(b);
    m_b = b;
  endtask

  task automatic good_fun(input logic [3:0] f);
    send({4'h0, f});
    m_fun = f;
    push_op(last_cyc + 1);
    push_tx(last_cyc + 3, last_cyc + 4, 1'b1);
  endtask

  task automatic rand_frame();
    int         kind;
    logic [7:0] fb;
    kind = $urandom_range(0, 4);
    if (kind == 2) begin
      do fb = 8'($urandom); while (fb == CMD_OPER || fb == CMD_NOOPER);
      send(fb);
      err_q.push_back('{int'(ERR_BAD_CMD), -1});
    end else begin
      if (kind == 0 || (kind != 1 && $urandom_range(0, 1) == 1))
        oper_frame(8'($urandom), 8'($urandom));
      else
        send(CMD_NOOPER);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      if (kind == 3) begin
        if ($urandom_range(0, 1) == 1) fb = 8'h0F;
        else fb = {4'($urandom_range(1, 15)), 4'($urandom)};
        send(fb);
        err_q.push_back('{int'(ERR_BAD_FUN), -1});
      end else begin
        alu_mute = (kind == 4);
        m_fun    = 4'($urandom_range(0, 14));
        send({4'h0, m_fun});
        push_op(-1);
        if (kind == 4) err_q.push_back('{int'(ERR_TIMEOUT), -1});
        else           push_tx(-1, -1, 1'b1);
        if ($urandom_range(0, 1) == 1) inject_junk();
      end
    end
    wait_idle();
    alu_mute = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(negedge CLK);
    chk("rst_alu_a", ALU_A, 0);
    chk("rst_alu_b", ALU_B, 0);
    chk("rst_alu_fun", ALU_FUN, 0);
    chk("rst_alu_en", ALU_EN, 0);
    chk("rst_tx_vld", TX_D_VLD, 0);
    chk("rst_tx_data", TX_P_DATA, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_cmd_err", CMD_ERR, 0);
    chk("rst_err_code", ERR_CODE, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;

    // Basic frame with exact latency and BUSY release.
    oper_frame(8'h05, 8'h03);
    good_fun(4'h0);
    repeat (4) @(negedge CLK);
    chk("busy_during_send_hi", BUSY, 1);
    @(negedge CLK);
    chk("busy_after_send", BUSY, 0);

    // Operand reuse across a no-operand frame.
    oper_frame(8'h10, 8'h20);
    good_fun(4'h2);
    wait_idle();
    send(CMD_NOOPER);
    good_fun(4'h0);
    wait_idle();

    // Bad opcode, then bad function byte.
    send(8'h7A);
    err_q.push_back('{int'(ERR_BAD_CMD), last_cyc + 1});
    @(negedge CLK);
    chk("bad_cmd_stays_idle", BUSY, 0);
    oper_frame(8'h01, 8'h02);
    send(8'h1F);
    err_q.push_back('{int'(ERR_BAD_FUN), last_cyc + 1});
    @(negedge CLK);
    chk("bad_fun_idle", BUSY, 0);
    chk("bad_fun_keeps_fun", ALU_FUN, m_fun);

    // ALU never answers.
    alu_mute = 1'b1;
    oper_frame(8'h33, 8'h44);
    send(8'h01);
    m_fun = 4'h1;
    push_op(last_cyc + 1);
    err_q.push_back('{int'(ERR_TIMEOUT), last_cyc + 6});
    wait_idle();
    repeat (3) @(negedge CLK);
    alu_mute = 1'b0;

    // FIFO full for three SEND_LO cycles with a stray RX byte arriving meanwhile.
    oper_frame(8'h9C, 8'h27);
    send(8'h02);
    m_fun = 4'h2;
    n = last_cyc;
    push_op(n + 1);
    push_tx(n + 6, n + 7, 1'b1);
    @(posedge CLK); #1; FIFO_FULL = 1'b1;
    @(posedge CLK); #1; RX_P_DATA = 8'hCC; RX_D_VLD = 1'b1;
    @(posedge CLK); #1; RX_D_VLD = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #1; FIFO_FULL = 1'b0;
    wait_idle();

    // Reset while the high byte is stalled.
    oper_frame(8'hA5, 8'h5A);
    send(8'h03);
    m_fun = 4'h3;
    n = last_cyc;
    push_op(n + 1);
    push_tx(n + 3, -1, 1'b0);
    @(posedge CLK);
    @(posedge CLK);
    @(posedge CLK); #1; FIFO_FULL = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
    @(negedge CLK);
    chk("midrst_alu_a", ALU_A, 0);
    chk("midrst_alu_b", ALU_B, 0);
    chk("midrst_alu_fun", ALU_FUN, 0);
    chk("midrst_tx_vld", TX_D_VLD, 0);
    chk("midrst_tx_data", TX_P_DATA, 0);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_err_code", ERR_CODE, 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    FIFO_FULL = 1'b0;
    m_a = '0;
    m_b = '0;
    m_fun = '0;
    send(CMD_NOOPER);
    good_fun(4'h6);
    wait_idle();

    // Randomized frames with random FIFO back-pressure and ALU latency.
    strict  = 1'b0;
    ff_rand = 1'b1;
    for (int i = 0; i < 150; i++) rand_frame();
    ff_rand = 1'b0;
    @(posedge CLK); #1; FIFO_FULL = 1'b0;
    repeat (12) @(negedge CLK);
    chk("tx_queue_drained", tx_q.size(), 0);
    chk("op_queue_drained", op_q.size(), 0);
    chk("err_queue_drained", err_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
